// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: request/grant bundle between eight requesters and the round-robin arbiter
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  modport master (output req, done, input grant, grant_idx, grant_valid, timeout);
  modport slave (input req, done, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with grant held until done; ARB_TIMEOUT_EN adds forced revoke after MAX_HOLD cycles
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter_8_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state, state_n;
  logic [2:0] ptr, ptr_n, idx, idx_n, pick;
  logic [7:0] grant_r;
  logic       tmo_r, expire, go, rel;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign expire = (state == BUSY) && !bus.done && (cnt == 8'(MAX_HOLD - 1));
  always_ff @(posedge clk)
    cnt <= (rst || state == IDLE) ? 8'd0 : cnt + 8'd1;
`else
  localparam logic [7:0] unused_hold = 8'(MAX_HOLD);
  assign expire = 1'b0;
`endif
  // scanning downward leaves the candidate closest to ptr as the winner
  always_comb begin
    pick = ptr;
    for (int k = 7; k >= 0; k--)
      if (bus.req[3'(ptr + 3'(k))]) pick = 3'(ptr + 3'(k));
  end
  always_comb begin
    go      = (state == IDLE) && (|bus.req);
    rel     = (state == BUSY) && (bus.done || expire);
    state_n = go ? BUSY : rel ? IDLE : state;
    idx_n   = go ? pick : idx;
    ptr_n   = rel ? idx + 3'd1 : ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      idx     <= 3'd0;
      grant_r <= 8'h00;
      tmo_r   <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      idx     <= idx_n;
      grant_r <= (state_n == BUSY) ? 8'b1 << idx_n : 8'h00;
      tmo_r   <= rel && expire;
    end
  end
  assign bus.grant       = grant_r;
  assign bus.grant_idx   = idx;
  assign bus.grant_valid = (state == BUSY);
  assign bus.timeout     = tmo_r;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed self-checking bench for rr_arbiter_8 (timeout checks follow ARB_TIMEOUT_EN, MAX_HOLD=4)
module tb_rr_arbiter_8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  rr_arbiter_8_if bus ();
  rr_arbiter_8 #(.MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic inv();
    chk("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    chk("valid_or", 32'(bus.grant_valid), 32'(|bus.grant));
    if (bus.grant_valid) chk("grant_idx_match", 32'(bus.grant), 32'(8'b1 << bus.grant_idx));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    inv();
  endtask
  task automatic expect_grant(input string tag, input logic [2:0] i);
    chk({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(8'b1 << i));
    chk({tag, "_idx"}, 32'(bus.grant_idx), 32'(i));
  endtask
  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.grant_valid), 32'd0);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
  endtask
  initial begin
    bus.req = 8'h00;
    bus.done = 1'b0;
    step();
    expect_idle("reset");
    chk("reset_idx", 32'(bus.grant_idx), 32'd0);
    chk("reset_tmo", 32'(bus.timeout), 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      expect_idle("noreq");
      chk("noreq_idx", 32'(bus.grant_idx), 32'd0);
    end
    bus.req = 8'h24;
    step(); expect_grant("r24_a", 3'd2);
    bus.done = 1'b1;
    step(); expect_idle("r24_rel");
    chk("r24_idx_hold", 32'(bus.grant_idx), 32'd2);
    bus.done = 1'b0;
    step(); expect_grant("r24_b", 3'd5);
    bus.done = 1'b1;
    step(); expect_idle("r24_rel2");
    bus.done = 1'b0;
    step(); expect_grant("r24_c", 3'd2);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req = 8'h00;
    step(); expect_idle("r24_end");
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step(); expect_grant("rr_ff", 3'(k));
      bus.done = 1'b1;
      step(); expect_idle("rr_gap");
      bus.done = 1'b0;
    end
    bus.req = 8'h80;
    step(); expect_grant("wrap_7", 3'd7);
    bus.req = 8'h81;
    bus.done = 1'b1;
    step(); expect_idle("wrap_rel");
    bus.done = 1'b0;
    step(); expect_grant("wrap_0", 3'd0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step(); expect_grant("wrap_7b", 3'd7);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req = 8'h00;
    step(); expect_idle("wrap_end");
    bus.req = 8'h08;
    step(); expect_grant("busy_3", 3'd3);
    bus.req = 8'h00;
    step(); expect_grant("busy_req0", 3'd3);
    bus.req = 8'hF0;
    step(); expect_grant("busy_reqf0", 3'd3);
    step(); expect_grant("busy_hold", 3'd3);
    rst = 1'b1;
    step(); expect_idle("busy_rst");
    chk("busy_rst_idx", 32'(bus.grant_idx), 32'd0);
    rst = 1'b0;
    bus.req = 8'hFF;
    step(); expect_grant("ptr_after_rst", 3'd0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req = 8'h06;
    step(); expect_grant("hold_1", 3'd1);
    chk("hold_tmo0", 32'(bus.timeout), 32'd0);
`ifdef ARB_TIMEOUT_EN
    for (int n = 0; n < 3; n++) begin
      step(); expect_grant("to_hold", 3'd1);
      chk("to_hold_tmo", 32'(bus.timeout), 32'd0);
    end
    step(); expect_idle("to_revoke");
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    step(); expect_grant("to_next", 3'd2);
    chk("to_pulse_end", 32'(bus.timeout), 32'd0);
`else
    for (int n = 0; n < 100; n++) begin
      step();
      chk("nt_grant", 32'(bus.grant), 32'h02);
      chk("nt_tmo", 32'(bus.timeout), 32'd0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
